systolic_pe_ws: RTL and testbench

- Parametrised weight-stationary processing element for the systolic matrix-multiply array.
- Successor of the fixed 4-bit PE, with these additions:
  - configurable data, weight and accumulator widths;
  - signed or unsigned arithmetic;
  - double-buffered weights, so a preload does not disturb compute;
  - explicit valid handshakes and saturating accumulation.
- Tiles into an R x C grid:
  - data flows west to east;
  - weights shift north to south during preload;
  - partial sums flow north to south.

---
 rtl/systolic_pkg.sv | 31 +++
 rtl/systolic_pe_ws_if.sv | 26 ++
 rtl/pe_mac_sat.sv | 48 ++++
 rtl/systolic_pe_ws.sv | 126 ++++++++++++
 tb/tb_systolic_pe_ws.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared types, default widths and clamp-limit helpers for the weight-stationary
// systolic processing element.
package systolic_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_ACC_WIDTH    = 20;

    typedef enum logic [1:0] {
        W_EMPTY,
        W_SHADOW,
        W_ACTIVE,
        W_ACTIVE_PEND
    } wstate_t;

    // Limits are returned as 64-bit patterns; callers keep the low width bits.
    function automatic logic [63:0] sat_max(input int width, input bit is_signed);
        sat_max = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width - (is_signed ? 1 : 0)) sat_max[i] = 1'b1;
        end
    endfunction

    function automatic logic [63:0] sat_min(input int width, input bit is_signed);
        sat_min = '0;
        for (int i = 0; i < 64; i++) begin
            if (is_signed && i >= width - 1) sat_min[i] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/systolic_pe_ws_if.sv
// Neighbour link of a systolic PE: activation, weight-preload and partial-sum
// streams travelling together between adjacent cells.
interface systolic_pe_ws_if
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH
);

    logic                    data_valid;
    logic [DATA_WIDTH-1:0]   data;
    logic                    weight_load;
    logic [WEIGHT_WIDTH-1:0] weight;
    logic                    psum_valid;
    logic [ACC_WIDTH-1:0]    psum;

    modport master (
        output data_valid, data, weight_load, weight, psum_valid, psum
    );

    modport slave (
        input data_valid, data, weight_load, weight, psum_valid, psum
    );

endinterface

// File: rtl/pe_mac_sat.sv
// Combinational multiply-accumulate with exact overflow detection and optional
// clamping, for signed or unsigned operands.
module pe_mac_sat
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter bit SIGNED       = 1'b1,
    parameter bit SATURATE     = 1'b1
) (
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [WEIGHT_WIDTH-1:0] weight,
    input  logic [ACC_WIDTH-1:0]    psum,
    output logic [ACC_WIDTH-1:0]    result,
    output logic                    ovf
);

    localparam int XW = ACC_WIDTH + 1;
    localparam logic [63:0] MAX64 = sat_max(ACC_WIDTH, SIGNED);
    localparam logic [63:0] MIN64 = sat_min(ACC_WIDTH, SIGNED);

    logic          d_ext, w_ext, p_ext;
    logic [XW-1:0] data_x, weight_x, psum_x, prod_x, sum_x;

    assign d_ext = SIGNED & data[DATA_WIDTH-1];
    assign w_ext = SIGNED & weight[WEIGHT_WIDTH-1];
    assign p_ext = SIGNED & psum[ACC_WIDTH-1];

    assign data_x   = {{(XW-DATA_WIDTH){d_ext}}, data};
    assign weight_x = {{(XW-WEIGHT_WIDTH){w_ext}}, weight};
    assign psum_x   = {p_ext, psum};

    // The product always fits in ACC_WIDTH bits, so the modular low bits are exact.
    assign prod_x = data_x * weight_x;
    assign sum_x  = psum_x + prod_x;

    // Signed: the two top bits disagree. Unsigned: carry out of the ACC_WIDTH range.
    assign ovf = SIGNED ? (sum_x[XW-1] != sum_x[XW-2]) : sum_x[XW-1];

    always_comb begin
        result = sum_x[ACC_WIDTH-1:0];
        if (ovf && SATURATE) begin
            result = (SIGNED && sum_x[XW-1]) ? MIN64[ACC_WIDTH-1:0] : MAX64[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/systolic_pe_ws.sv
// Weight-stationary systolic PE: double-buffered weights, forwarded activations
// and a registered saturating partial-sum stage.
module systolic_pe_ws
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter bit SIGNED       = 1'b1,
    parameter bit SATURATE     = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic weight_commit,
    systolic_pe_ws_if.slave  up,
    systolic_pe_ws_if.master down,
    output logic weight_ready,
    output logic overflow
);

    wstate_t                 state;
    logic [WEIGHT_WIDTH-1:0] shadow, active, mac_weight;
    logic [ACC_WIDTH-1:0]    psum_in_eff, mac_result, psum_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    mac_ovf, data_valid_q, weight_load_q, psum_valid_q;

    assign psum_in_eff = up.psum_valid ? up.psum : '0;
    assign mac_weight  = weight_ready ? active : '0;

    pe_mac_sat #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .SIGNED      (SIGNED),
        .SATURATE    (SATURATE)
    ) u_mac (
        .data  (up.data),
        .weight(mac_weight),
        .psum  (psum_in_eff),
        .result(mac_result),
        .ovf   (mac_ovf)
    );

    // Commit copies the pre-edge shadow, so a simultaneous load never leaks into active.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= W_EMPTY;
            active       <= '0;
            weight_ready <= 1'b0;
        end else if (clear) begin
            state        <= W_EMPTY;
            active       <= '0;
            weight_ready <= 1'b0;
        end else begin
            case (state)
                W_EMPTY: begin
                    if (up.weight_load) state <= W_SHADOW;
                end
                W_SHADOW: begin
                    if (weight_commit) begin
                        active       <= shadow;
                        weight_ready <= 1'b1;
                        state        <= up.weight_load ? W_ACTIVE_PEND : W_ACTIVE;
                    end
                end
                W_ACTIVE: begin
                    if (weight_commit) active <= shadow;
                    if (up.weight_load) state <= W_ACTIVE_PEND;
                end
                W_ACTIVE_PEND: begin
                    if (weight_commit) begin
                        active <= shadow;
                        if (!up.weight_load) state <= W_ACTIVE;
                    end
                end
                default: state <= W_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow        <= '0;
            weight_load_q <= 1'b0;
        end else if (clear) begin
            shadow        <= '0;
            weight_load_q <= 1'b0;
        end else begin
            if (up.weight_load) shadow <= up.weight;
            weight_load_q <= up.weight_load;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_valid_q <= 1'b0;
            data_q       <= '0;
            psum_valid_q <= 1'b0;
            psum_q       <= '0;
            overflow     <= 1'b0;
        end else if (clear) begin
            data_valid_q <= 1'b0;
            data_q       <= '0;
            psum_valid_q <= 1'b0;
            psum_q       <= '0;
            overflow     <= 1'b0;
        end else begin
            data_valid_q <= up.data_valid;
            psum_valid_q <= up.data_valid;
            if (up.data_valid) begin
                data_q <= up.data;
                psum_q <= mac_result;
                if (mac_ovf) overflow <= 1'b1;
            end
        end
    end

    assign down.data_valid  = data_valid_q;
    assign down.data        = data_q;
    assign down.weight_load = weight_load_q;
    assign down.weight      = shadow;
    assign down.psum_valid  = psum_valid_q;
    assign down.psum        = psum_q;

endmodule

// File: tb/tb_systolic_pe_ws.sv
// Drives one stimulus stream into signed-saturating, signed-wrapping and
// unsigned-saturating PEs and compares them with an arithmetic reference model.
module tb_systolic_pe_ws;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clear;
    logic        weight_commit;
    logic        data_valid_in;
    logic [7:0]  data_in;
    logic        weight_load;
    logic [7:0]  weight_in;
    logic        psum_valid_in;
    logic [19:0] psum_in;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    systolic_pe_ws_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(20)) up_ss ();
    systolic_pe_ws_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(20)) dn_ss ();
    systolic_pe_ws_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(20)) up_sw ();
    systolic_pe_ws_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(20)) dn_sw ();
    systolic_pe_ws_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(20)) up_us ();
    systolic_pe_ws_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(20)) dn_us ();

    assign up_ss.data_valid = data_valid_in;
    assign up_ss.data = data_in;
    assign up_ss.weight_load = weight_load;
    assign up_ss.weight = weight_in;
    assign up_ss.psum_valid = psum_valid_in;
    assign up_ss.psum = psum_in;
    assign up_sw.data_valid = data_valid_in;
    assign up_sw.data = data_in;
    assign up_sw.weight_load = weight_load;
    assign up_sw.weight = weight_in;
    assign up_sw.psum_valid = psum_valid_in;
    assign up_sw.psum = psum_in;
    assign up_us.data_valid = data_valid_in;
    assign up_us.data = data_in;
    assign up_us.weight_load = weight_load;
    assign up_us.weight = weight_in;
    assign up_us.psum_valid = psum_valid_in;
    assign up_us.psum = psum_in;

    logic [2:0] ready_obs, ovf_obs;

    systolic_pe_ws #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(20), .SIGNED(1'b1), .SATURATE(1'b1))
    dut_ss (.clk(clk), .rstn(rstn), .clear(clear), .weight_commit(weight_commit),
            .up(up_ss.slave), .down(dn_ss.master),
            .weight_ready(ready_obs[0]), .overflow(ovf_obs[0]));

    systolic_pe_ws #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(20), .SIGNED(1'b1), .SATURATE(1'b0))
    dut_sw (.clk(clk), .rstn(rstn), .clear(clear), .weight_commit(weight_commit),
            .up(up_sw.slave), .down(dn_sw.master),
            .weight_ready(ready_obs[1]), .overflow(ovf_obs[1]));

    systolic_pe_ws #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .ACC_WIDTH(20), .SIGNED(1'b0), .SATURATE(1'b1))
    dut_us (.clk(clk), .rstn(rstn), .clear(clear), .weight_commit(weight_commit),
            .up(up_us.slave), .down(dn_us.master),
            .weight_ready(ready_obs[2]), .overflow(ovf_obs[2]));

    logic [2:0]       dv_obs, wl_obs, pv_obs;
    logic [2:0][7:0]  data_obs, weight_obs;
    logic [2:0][19:0] psum_obs;

    assign dv_obs     = {dn_us.data_valid, dn_sw.data_valid, dn_ss.data_valid};
    assign wl_obs     = {dn_us.weight_load, dn_sw.weight_load, dn_ss.weight_load};
    assign pv_obs     = {dn_us.psum_valid, dn_sw.psum_valid, dn_ss.psum_valid};
    assign data_obs   = {dn_us.data, dn_sw.data, dn_ss.data};
    assign weight_obs = {dn_us.weight, dn_sw.weight, dn_ss.weight};
    assign psum_obs   = {dn_us.psum, dn_sw.psum, dn_ss.psum};

    // Reference model: config 0 = signed/saturate, 1 = signed/wrap, 2 = unsigned/saturate.
    logic [7:0]       m_shadow, m_active, m_data;
    bit               m_loaded, m_ready, m_dv, m_wl, m_pv;
    logic [2:0][19:0] m_psum;
    logic [2:0]       m_ovf;
    logic [19:0]      rp;

    function automatic logic [20:0] macRef(input int cfg, input logic [19:0] psum,
                                           input logic [7:0] d, input logic [7:0] w);
        bit     sgn, sat, ovf;
        longint p, dd, ww, exact, lo, hi, res;
        sgn = (cfg != 2);
        sat = (cfg != 1);
        if (sgn) begin
            p  = longint'($signed(psum));
            dd = longint'($signed(d));
            ww = longint'($signed(w));
            lo = -(longint'(1) << 19);
            hi = (longint'(1) << 19) - 1;
        end else begin
            p  = longint'(psum);
            dd = longint'(d);
            ww = longint'(w);
            lo = 0;
            hi = (longint'(1) << 20) - 1;
        end
        exact = p + dd * ww;
        ovf   = (exact < lo) || (exact > hi);
        res   = exact;
        if (ovf && sat) res = (exact > hi) ? hi : lo;
        return {ovf, res[19:0]};
    endfunction

    task automatic modelReset();
        m_shadow = '0; m_active = '0; m_data = '0;
        m_loaded = 0; m_ready = 0; m_dv = 0; m_wl = 0; m_pv = 0;
        m_psum = '0; m_ovf = '0;
    endtask

    task automatic modelStep();
        logic [20:0] r;
        if (clear) begin
            modelReset();
        end else begin
            if (data_valid_in) begin
                for (int c = 0; c < 3; c++) begin
                    r = macRef(c, psum_valid_in ? psum_in : 20'd0, data_in,
                               m_ready ? m_active : 8'd0);
                    m_psum[c] = r[19:0];
                    if (r[20]) m_ovf[c] = 1'b1;
                end
                m_data = data_in;
            end
            m_dv = data_valid_in;
            m_pv = data_valid_in;
            m_wl = weight_load;
            if (weight_commit && m_loaded) begin
                m_active = m_shadow;
                m_ready  = 1;
            end
            if (weight_load) begin
                m_shadow = weight_in;
                m_loaded = 1;
            end
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        for (int c = 0; c < 3; c++) begin
            checkVal($sformatf("data_valid_c%0d", c), 32'(dv_obs[c]), 32'(m_dv));
            checkVal($sformatf("data_c%0d", c), 32'(data_obs[c]), 32'(m_data));
            checkVal($sformatf("weight_load_c%0d", c), 32'(wl_obs[c]), 32'(m_wl));
            checkVal($sformatf("weight_c%0d", c), 32'(weight_obs[c]), 32'(m_shadow));
            checkVal($sformatf("psum_valid_c%0d", c), 32'(pv_obs[c]), 32'(m_pv));
            checkVal($sformatf("psum_c%0d", c), 32'(psum_obs[c]), 32'(m_psum[c]));
            checkVal($sformatf("ready_c%0d", c), 32'(ready_obs[c]), 32'(m_ready));
            checkVal($sformatf("overflow_c%0d", c), 32'(ovf_obs[c]), 32'(m_ovf[c]));
        end
    endtask

    task automatic applyStimulus(input bit dv, input logic [7:0] d, input bit wl,
                                 input logic [7:0] w, input bit wc, input bit pv,
                                 input logic [19:0] p, input bit clr);
        data_valid_in = dv; data_in = d; weight_load = wl; weight_in = w;
        weight_commit = wc; psum_valid_in = pv; psum_in = p; clear = clr;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(0, 8'd0, 0, 8'd0, 0, 0, 20'd0, 0);
    endtask

    initial begin
        rstn = 1'b0;
        clear = 0; weight_commit = 0; data_valid_in = 0; data_in = '0;
        weight_load = 0; weight_in = '0; psum_valid_in = 0; psum_in = '0;
        modelReset();
        #12;
        checkOutput();
        @(negedge clk);
        rstn = 1'b1;

        // Basic preload, commit and one MAC beat
        applyStimulus(0, 8'd0, 1, 8'd3, 0, 0, 20'd0, 0);
        applyStimulus(0, 8'd0, 0, 8'd0, 1, 0, 20'd0, 0);
        applyStimulus(1, 8'd5, 0, 8'd0, 0, 1, 20'd10, 0);
        checkVal("tp1_psum", 32'(dn_ss.psum), 32'd25);
        checkVal("tp1_data", 32'(dn_ss.data), 32'd5);

        // Negative weight, then full-scale unsigned
        applyStimulus(0, 8'd0, 1, 8'hFC, 0, 0, 20'd0, 0);
        applyStimulus(0, 8'd0, 0, 8'd0, 1, 0, 20'd0, 0);
        applyStimulus(1, 8'd7, 0, 8'd0, 0, 1, 20'd0, 0);
        checkVal("tp2_signed", 32'(dn_ss.psum), 32'h000FFFE4);
        applyStimulus(0, 8'd0, 1, 8'd255, 1, 0, 20'd0, 0);
        applyStimulus(0, 8'd0, 0, 8'd0, 1, 0, 20'd0, 0);
        applyStimulus(1, 8'd255, 0, 8'd0, 0, 0, 20'd0, 0);
        checkVal("tp2_unsigned", 32'(dn_us.psum), 32'd65025);

        // Positive overflow: clamp vs wrap, sticky flag
        applyStimulus(0, 8'd0, 1, 8'd1, 0, 0, 20'd0, 0);
        applyStimulus(0, 8'd0, 0, 8'd0, 1, 0, 20'd0, 0);
        applyStimulus(1, 8'd1, 0, 8'd0, 0, 1, 20'd524287, 0);
        checkVal("tp3_sat", 32'(dn_ss.psum), 32'd524287);
        checkVal("tp3_wrap", 32'(dn_sw.psum), 32'h00080000);
        repeat (3) idle();
        checkVal("tp3_sticky", 32'(ovf_obs[0]), 32'd1);

        // Load and commit alongside streaming beats
        applyStimulus(0, 8'd0, 1, 8'd2, 0, 0, 20'd0, 0);
        applyStimulus(0, 8'd0, 1, 8'd5, 1, 0, 20'd0, 0);
        applyStimulus(1, 8'd1, 1, 8'd9, 1, 0, 20'd0, 0);
        checkVal("tp4_beat_old", 32'(dn_ss.psum), 32'd2);
        checkVal("tp4_weight_out", 32'(dn_ss.weight), 32'd9);
        applyStimulus(1, 8'd1, 0, 8'd0, 1, 0, 20'd0, 0);
        checkVal("tp4_beat_shadow", 32'(dn_ss.psum), 32'd5);
        applyStimulus(1, 8'd1, 0, 8'd0, 0, 0, 20'd0, 0);
        checkVal("tp4_beat_new", 32'(dn_ss.psum), 32'd9);

        // Commit with nothing loaded is ignored
        applyStimulus(0, 8'd0, 0, 8'd0, 0, 0, 20'd0, 1);
        applyStimulus(0, 8'd0, 0, 8'd0, 1, 0, 20'd0, 0);
        checkVal("tp5_ready", 32'(ready_obs[0]), 32'd0);
        applyStimulus(1, 8'd6, 0, 8'd0, 0, 1, 20'd11, 0);
        checkVal("tp5_pass", 32'(dn_ss.psum), 32'd11);

        // Asynchronous reset mid-stream
        applyStimulus(1, 8'd4, 1, 8'd7, 0, 1, 20'd100, 0);
        rstn = 1'b0;
        #1;
        modelReset();
        checkOutput();
        checkVal("tp6_async_pv", 32'(dn_ss.psum_valid), 32'd0);
        #2;
        rstn = 1'b1;

        // Synchronous clear beats a concurrent valid beat
        applyStimulus(0, 8'd0, 1, 8'd127, 0, 0, 20'd0, 0);
        applyStimulus(0, 8'd0, 0, 8'd0, 1, 0, 20'd0, 0);
        applyStimulus(1, 8'd127, 0, 8'd0, 0, 1, 20'h7F000, 0);
        applyStimulus(1, 8'd3, 0, 8'd0, 0, 1, 20'd1, 1);
        checkVal("tp6_clear_pv", 32'(dn_ss.psum_valid), 32'd0);
        checkVal("tp6_clear_ovf", 32'(ovf_obs[0]), 32'd0);
        checkVal("tp6_clear_ready", 32'(ready_obs[0]), 32'd0);

        // Randomised traffic, biased towards the accumulator limits
        for (int k = 0; k < 400; k++) begin
            rp = 20'($urandom);
            if ($urandom_range(0, 2) == 0) rp[18:8] = '1;
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom),
                          $urandom_range(0, 4) == 0, 8'($urandom),
                          $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                          rp, $urandom_range(0, 60) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
